// File: rtl/fa_response_checker.sv
// fa_response_checker
//   Receive/compare end of an exhaustive 3-bit full-adder sweep. Each valid
//   observation {a,b,cin,sum,cout} is checked against an internal golden
//   adder; mismatches are counted (saturating), coverage of the 8 input
//   combinations is tracked, and a registered pass/fail verdict is produced
//   after NUM_VECTORS accepted vectors.
//
// Ports
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   start_i              one-cycle pulse that begins a run (IDLE or DONE)
//   vld_i                a_i/b_i/cin_i/sum_i/cout_i form a valid observation
//   a_i, b_i, cin_i      applied adder inputs
//   sum_i, cout_i        observed adder outputs
//   busy_o               run in progress
//   done_o               run complete, verdict valid
//   pass_o               no mismatches and full coverage (valid with done_o)
//   err_cnt_o            saturating mismatch count
//   vec_cnt_o            accepted vector count
//   cov_o                bit k set once {a,b,cin}==k has been seen
//   first_fail_vld_o     a mismatch has been captured
//   first_fail_o         {a,b,cin,sum,cout} of the first mismatch
module fa_response_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int VEC_CNT_W   = 8,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 vld_i,
  input  logic                 a_i,
  input  logic                 b_i,
  input  logic                 cin_i,
  input  logic                 sum_i,
  input  logic                 cout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [VEC_CNT_W-1:0] vec_cnt_o,
  output logic [7:0]           cov_o,
  output logic                 first_fail_vld_o,
  output logic [4:0]           first_fail_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [VEC_CNT_W-1:0] LAST_VEC = VEC_CNT_W'(NUM_VECTORS);

  state_t               state;
  logic                 exp_sum;
  logic                 exp_cout;
  logic                 mismatch;
  logic [2:0]           vec_idx;
  logic [ERR_CNT_W-1:0] err_nxt;
  logic [VEC_CNT_W-1:0] vec_nxt;
  logic [7:0]           cov_nxt;

  // Golden adder and the counter values an accepted vector would produce;
  // the verdict is formed from these so it includes the final vector.
  always_comb begin
    vec_idx  = {a_i, b_i, cin_i};
    exp_sum  = a_i ^ b_i ^ cin_i;
    exp_cout = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    mismatch = (sum_i != exp_sum) || (cout_i != exp_cout);
    err_nxt  = err_cnt_o;
    if (mismatch && (err_cnt_o != '1)) begin
      err_nxt = err_cnt_o + 1'b1;
    end
    vec_nxt = vec_cnt_o + 1'b1;
    cov_nxt = cov_o | (8'(1) << vec_idx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_cnt_o        <= '0;
      vec_cnt_o        <= '0;
      cov_o            <= '0;
      first_fail_vld_o <= 1'b0;
      first_fail_o     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state            <= CHECK;
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_cnt_o        <= '0;
            vec_cnt_o        <= '0;
            cov_o            <= '0;
            first_fail_vld_o <= 1'b0;
            first_fail_o     <= '0;
          end
        end
        CHECK: begin
          if (vld_i) begin
            vec_cnt_o <= vec_nxt;
            cov_o     <= cov_nxt;
            err_cnt_o <= err_nxt;
            if (mismatch && !first_fail_vld_o) begin
              first_fail_vld_o <= 1'b1;
              first_fail_o     <= {a_i, b_i, cin_i, sum_i, cout_i};
            end
            if (vec_nxt == LAST_VEC) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= (err_nxt == '0) && (cov_nxt == 8'hFF);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_response_checker.sv
module tb_fa_response_checker;

  logic clk = 1'b0;
  logic rst, start, vld, a, b, cin, sum, cout;

  logic       busy1, done1, pass1, ffv1;
  logic [7:0] err1, vec1, cov1;
  logic [4:0] ff1;
  logic       busy2, done2, pass2, ffv2;
  logic [1:0] err2;
  logic [7:0] vec2, cov2;
  logic [4:0] ff2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         verdict;  // 1: compared when done_o rises; 0: at next negedge
    string      name;
    logic       busy, done, pass;
    logic [7:0] err, vec, cov;
    logic       ffv;
    logic [4:0] ff;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  fa_response_checker #(.NUM_VECTORS(8), .VEC_CNT_W(8), .ERR_CNT_W(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vld_i(vld),
    .a_i(a), .b_i(b), .cin_i(cin), .sum_i(sum), .cout_i(cout),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
    .vec_cnt_o(vec1), .cov_o(cov1), .first_fail_vld_o(ffv1), .first_fail_o(ff1)
  );

  fa_response_checker #(.NUM_VECTORS(8), .VEC_CNT_W(8), .ERR_CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .vld_i(vld),
    .a_i(a), .b_i(b), .cin_i(cin), .sum_i(sum), .cout_i(cout),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err2),
    .vec_cnt_o(vec2), .cov_o(cov2), .first_fail_vld_o(ffv2), .first_fail_o(ff2)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(string name, bit verdict, logic busy, logic done,
                              logic pass, int err, int vec, logic [7:0] cov,
                              logic ffv, logic [4:0] ff);
    exp_t e;
    e.name = name; e.verdict = verdict; e.busy = busy; e.done = done;
    e.pass = pass; e.err = 8'(err); e.vec = 8'(vec); e.cov = cov;
    e.ffv = ffv; e.ff = ff;
    return e;
  endfunction

  // The 2-bit-counter instance sees the same traffic; its count saturates at 3.
  task automatic push(exp_t e);
    exp_t e2;
    e2 = e;
    if (e2.err > 8'd3) e2.err = 8'd3;
    e2.name = {e.name, "_w2"};
    q1.push_back(e);
    q2.push_back(e2);
  endtask

  task automatic cmp(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check(exp_t e, logic busy, logic done, logic pass,
                       logic [7:0] err, logic [7:0] vec, logic [7:0] cov,
                       logic ffv, logic [4:0] ff);
    cmp({e.name, ".busy"}, busy, e.busy);
    cmp({e.name, ".done"}, done, e.done);
    cmp({e.name, ".pass"}, pass, e.pass);
    cmp({e.name, ".err_cnt"}, err, e.err);
    cmp({e.name, ".vec_cnt"}, vec, e.vec);
    cmp({e.name, ".cov"}, cov, e.cov);
    cmp({e.name, ".first_fail_vld"}, ffv, e.ffv);
    cmp({e.name, ".first_fail"}, ff, e.ff);
  endtask

  logic prev1 = 1'b0;
  logic prev2 = 1'b0;

  always @(negedge clk) begin
    if (q1.size() != 0 && !q1[0].verdict) begin
      check(q1.pop_front(), busy1, done1, pass1, err1, vec1, cov1, ffv1, ff1);
    end else if (done1 && !prev1) begin
      if (q1.size() != 0 && q1[0].verdict)
        check(q1.pop_front(), busy1, done1, pass1, err1, vec1, cov1, ffv1, ff1);
      else begin
        tests++; fails++;
        $display("FAIL dut1_unexpected_done: got done=1, expected no verdict");
      end
    end
    prev1 = done1;
  end

  always @(negedge clk) begin
    if (q2.size() != 0 && !q2[0].verdict) begin
      check(q2.pop_front(), busy2, done2, pass2, {6'd0, err2}, vec2, cov2, ffv2, ff2);
    end else if (done2 && !prev2) begin
      if (q2.size() != 0 && q2[0].verdict)
        check(q2.pop_front(), busy2, done2, pass2, {6'd0, err2}, vec2, cov2, ffv2, ff2);
      else begin
        tests++; fails++;
        $display("FAIL dut2_unexpected_done: got done=1, expected no verdict");
      end
    end
    prev2 = done2;
  end

  // Drive one cycle of inputs; fs/fc flip the correct sum/cout.
  task automatic beat(bit st, bit v, logic [2:0] x, bit fs, bit fc);
    start = st; vld = v; {a, b, cin} = x;
    sum  = (x[2] ^ x[1] ^ x[0]) ^ fs;
    cout = ((x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0])) ^ fc;
    @(posedge clk);
    #1;
    start = 1'b0; vld = 1'b0;
  endtask

  task automatic drain(string tag);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d pending, expected 0", tag, q1.size() + q2.size());
      q1.delete(); q2.delete();
    end
    #1;
  endtask

  task automatic sweep(logic [7:0] fs_m, logic [7:0] fc_m, exp_t verdict);
    for (int unsigned i = 0; i < 8; i++) begin
      if (i == 7) push(verdict);
      beat(1'b0, 1'b1, 3'(i), fs_m[i], fc_m[i]);
    end
    drain(verdict.name);
  endtask

  logic [2:0] gap_vecs [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};

  initial begin
    rst = 1'b1; start = 1'b0; vld = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0; sum = 1'b0; cout = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    push(mk("reset", 0, 0, 0, 0, 0, 0, 8'h00, 0, 5'b00000));
    rst = 1'b0;
    drain("reset");

    // clean exhaustive sweep
    beat(1, 0, 3'd0, 0, 0);
    sweep(8'h00, 8'h00, mk("clean", 1, 0, 1, 1, 0, 8, 8'hFF, 0, 5'b00000));

    // sum forced 0 at 3'b100, cout forced 0 at 3'b111
    beat(1, 0, 3'd0, 0, 0);
    sweep(8'h10, 8'h80, mk("faults", 1, 0, 1, 0, 2, 8, 8'hFF, 1, 5'b10000));

    // gaps (ignored beats carry bad data), 3'b010 twice, 3'b110 never
    beat(1, 0, 3'd0, 0, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      beat(0, 0, 3'd6, 1, 1);
      if (i == 7) push(mk("gaps", 1, 0, 1, 0, 0, 8, 8'hBF, 0, 5'b00000));
      beat(0, 1, gap_vecs[i], 0, 0);
    end
    drain("gaps");

    // reset in the middle of a run
    beat(1, 0, 3'd0, 0, 0);
    beat(0, 1, 3'd0, 0, 0);
    beat(0, 1, 3'd1, 1, 0);
    beat(0, 1, 3'd2, 0, 0);
    beat(0, 1, 3'd3, 0, 0);
    push(mk("midrun", 0, 1, 0, 0, 1, 4, 8'h0F, 1, 5'b00100));
    drain("midrun");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push(mk("midreset", 0, 0, 0, 0, 0, 0, 8'h00, 0, 5'b00000));
    drain("midreset");
    beat(1, 0, 3'd0, 0, 0);
    sweep(8'h00, 8'h00, mk("after_reset", 1, 0, 1, 1, 0, 8, 8'hFF, 0, 5'b00000));

    // start during CHECK is ignored
    beat(1, 0, 3'd0, 0, 0);
    beat(0, 1, 3'd0, 0, 0);
    beat(0, 1, 3'd1, 0, 0);
    beat(0, 1, 3'd2, 0, 0);
    beat(1, 1, 3'd3, 0, 0);
    push(mk("start_in_check", 0, 1, 0, 0, 0, 4, 8'h0F, 0, 5'b00000));
    drain("start_in_check");
    beat(0, 1, 3'd4, 0, 0);
    beat(0, 1, 3'd5, 0, 0);
    beat(0, 1, 3'd6, 0, 0);
    push(mk("check_cont", 1, 0, 1, 1, 0, 8, 8'hFF, 0, 5'b00000));
    beat(0, 1, 3'd7, 0, 0);
    drain("check_cont");

    // DONE holds outputs, ignores vld; start restarts and ignores vld
    beat(0, 1, 3'd5, 1, 0);
    push(mk("done_hold", 0, 0, 1, 1, 0, 8, 8'hFF, 0, 5'b00000));
    drain("done_hold");
    beat(1, 1, 3'd5, 1, 0);
    push(mk("restart", 0, 1, 0, 0, 0, 0, 8'h00, 0, 5'b00000));
    drain("restart");
    sweep(8'h00, 8'h00, mk("restart_run", 1, 0, 1, 1, 0, 8, 8'hFF, 0, 5'b00000));

    // every vector wrong: 8 errors, 3 on the 2-bit counter
    beat(1, 0, 3'd0, 0, 0);
    sweep(8'hFF, 8'h00, mk("saturate", 1, 0, 1, 0, 8, 8, 8'hFF, 1, 5'b00010));

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fa_response_checker.md
Name: fa_response_checker

Overview:
Synthesizable response checker for the full_adder block; the receive/compare end of the exhaustive 3-bit stimulus sweep applied to a full adder. It observes each applied {a,b,cin} vector together with the adder's sum/cout, computes the golden result internally, and counts mismatches. It tracks coverage of all 8 input combinations and reports a registered pass/fail verdict after a programmed number of vectors. It sits beside the full_adder instance (on-chip BIST or FPGA bring-up) and is driven by any vector source.

Parameters:
NUM_VECTORS, 8, number of accepted vectors per run; legal range 1..2**VEC_CNT_W-1
VEC_CNT_W, 8, width of the vector counter
ERR_CNT_W, 8, width of the mismatch counter; saturates at all-ones

Ports:
clk_i  input  1  clock; all logic on the rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  one-cycle pulse that begins a run
vld_i  input  1  current a_i/b_i/cin_i/sum_i/cout_i form a valid observation
a_i  input  1  applied adder operand a
b_i  input  1  applied adder operand b
cin_i  input  1  applied carry-in
sum_i  input  1  observed adder sum
cout_i  input  1  observed adder carry-out
busy_o  output  1  run in progress (CHECK state)
done_o  output  1  run complete; verdict valid
pass_o  output  1  zero mismatches AND full coverage; valid only while done_o=1
err_cnt_o  output  ERR_CNT_W  mismatch count for the current/last run
vec_cnt_o  output  VEC_CNT_W  vectors accepted in the current/last run
cov_o  output  8  bit k set once vector {a,b,cin}==k has been seen
first_fail_vld_o  output  1  at least one mismatch captured
first_fail_o  output  5  {a,b,cin,sum,cout} of the first mismatching observation

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE. All outputs 0. Reset overrides every other input, including in the middle of a run.
- Golden model: exp_sum = a^b^cin; exp_cout = (a&b)|(a&cin)|(b&cin). A mismatch is sum_i!=exp_sum OR cout_i!=exp_cout.
- States: IDLE, CHECK, DONE.
- IDLE: on start_i go to CHECK. On that same edge, clear err_cnt, vec_cnt, cov, first_fail_vld and first_fail, and clear done_o and pass_o. vld_i is ignored in IDLE and on the start edge.
- CHECK: busy_o=1.
  - Each edge with vld_i=1 is one accepted vector. vec_cnt increments by 1. cov[{a_i,b_i,cin_i}] is set.
  - On a mismatch, err_cnt increments and saturates at 2**ERR_CNT_W-1.
  - On a mismatch with first_fail_vld=0, first_fail is captured and first_fail_vld is set. Later mismatches do not overwrite the capture.
  - Edges with vld_i=0 change nothing.
  - start_i is ignored in CHECK.
- CHECK to DONE happens on the edge that accepts vector number NUM_VECTORS; the counters are updated on that same edge.
  - From the next cycle: busy_o=0, done_o=1.
  - pass_o = (err_cnt==0) && (cov==8'hFF), registered on the transition edge and including the final vector.
  - With NUM_VECTORS<8, pass_o=0 even with no errors (coverage incomplete).
- DONE: all outputs are held; vld_i is ignored. start_i starts a new run exactly as from IDLE.
- Latency: every status output reflects an accepted vector on the cycle after the edge that accepts it.
- All status outputs are registered; there is no combinational path from inputs to outputs.
- Repeated vectors count toward vec_cnt; a repeated vector leaves its cov bit at 1.

Test Plan:
- Exhaustive clean sweep: start_i, then 8 consecutive vld_i cycles with {a,b,cin}=0..7 and correct sum/cout -> after the 8th edge, done_o=1, pass_o=1, err_cnt_o=0, vec_cnt_o=8, cov_o=8'hFF, first_fail_vld_o=0.
- Injected faults: same sweep, but force sum_i=0 at vector 3'b100 and cout_i=0 at vector 3'b111 -> err_cnt_o=2, pass_o=0, first_fail_vld_o=1, first_fail_o=5'b10000.
- Gaps and repeats: vld_i toggled every other cycle; vector 3'b010 applied twice and 3'b110 never applied -> done_o is asserted after the 8th valid beat, cov_o=8'hBF, pass_o=0, err_cnt_o=0.
- Reset mid-run: after 4 valid vectors, rst_i=1 for one cycle -> next cycle all outputs are 0 and state is IDLE; a new start_i plus a clean sweep then gives pass_o=1.
- Restart and ignored start: start_i asserted during CHECK has no effect (vec_cnt continues). start_i in DONE clears err_cnt_o, cov_o and done_o on the next cycle, and busy_o=1.
- Saturation: ERR_CNT_W=2, NUM_VECTORS=8, every vector wrong -> err_cnt_o=3, pass_o=0.
